// File: rtl/arm_ctrl_pkg.sv
// Shared constants and types for the ARM ID-stage control sequencer.
// Opcode, mode and ALU command encodings plus the FSM state type.
package arm_ctrl_pkg;

   localparam logic [1:0] MODE_DP  = 2'b00;
   localparam logic [1:0] MODE_MEM = 2'b01;
   localparam logic [1:0] MODE_BR  = 2'b10;
   localparam logic [1:0] MODE_RSV = 2'b11;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_EOR  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_SORT = 4'b0011;
   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_ADC  = 4'b0101;
   localparam logic [3:0] OP_SBC  = 4'b0110;
   localparam logic [3:0] OP_TST  = 4'b1000;
   localparam logic [3:0] OP_CMP  = 4'b1010;
   localparam logic [3:0] OP_ORR  = 4'b1100;
   localparam logic [3:0] OP_MOV  = 4'b1101;
   localparam logic [3:0] OP_MVN  = 4'b1111;

   localparam logic [3:0] ALU_MOV      = 4'b0001;
   localparam logic [3:0] ALU_ADD      = 4'b0010;
   localparam logic [3:0] ALU_ADC      = 4'b0011;
   localparam logic [3:0] ALU_SUB      = 4'b0100;
   localparam logic [3:0] ALU_SBC      = 4'b0101;
   localparam logic [3:0] ALU_AND      = 4'b0110;
   localparam logic [3:0] ALU_ORR      = 4'b0111;
   localparam logic [3:0] ALU_EOR      = 4'b1000;
   localparam logic [3:0] ALU_MVN      = 4'b1001;
   localparam logic [3:0] ALU_SORT_CMP = 4'b1010;
   localparam logic [3:0] ALU_SORT_SWP = 4'b1011;

   typedef enum logic {IDLE, SEQ} state_t;

   typedef struct packed {
      logic [3:0] alu_cmd;
      logic       mem_read;
      logic       mem_write;
      logic       wb_en;
      logic       branch;
      logic       s_out;
   } ctrl_t;

   function automatic logic [3:0] alu_of(input logic [3:0] op);
      case (op)
         OP_MOV:  alu_of = ALU_MOV;
         OP_MVN:  alu_of = ALU_MVN;
         OP_ADD:  alu_of = ALU_ADD;
         OP_ADC:  alu_of = ALU_ADC;
         OP_SUB:  alu_of = ALU_SUB;
         OP_SBC:  alu_of = ALU_SBC;
         OP_AND:  alu_of = ALU_AND;
         OP_ORR:  alu_of = ALU_ORR;
         OP_EOR:  alu_of = ALU_EOR;
         OP_CMP:  alu_of = ALU_SUB;
         OP_TST:  alu_of = ALU_AND;
         default: alu_of = ALU_MOV;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Instruction-in / control-out bundle between front end and sequencer.
// The sequencer is the slave; the front end (or bench) is the master.
interface ctrl_sequencer_if #(parameter int STEP_W = 1);

   logic              valid_in;
   logic [1:0]        mode;
   logic [3:0]        opcode;
   logic              s_in;
   logic              freeze;
   logic              flush;
   logic [3:0]        alu_cmd;
   logic              mem_read;
   logic              mem_write;
   logic              wb_en;
   logic              branch;
   logic              s_out;
   logic              valid_out;
   logic              stall_out;
   logic [STEP_W-1:0] step;
   logic              last_step;

   modport master (
      output valid_in, mode, opcode, s_in, freeze, flush,
      input  alu_cmd, mem_read, mem_write, wb_en, branch, s_out,
      input  valid_out, stall_out, step, last_step
   );

   modport slave (
      input  valid_in, mode, opcode, s_in, freeze, flush,
      output alu_cmd, mem_read, mem_write, wb_en, branch, s_out,
      output valid_out, stall_out, step, last_step
   );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational single-cycle decode of mode/opcode/S into control enables.
// An absent instruction decodes to an all-zero bubble.
module ctrl_decode
   import arm_ctrl_pkg::*;
(
   input  logic       valid,
   input  logic [1:0] mode,
   input  logic [3:0] opcode,
   input  logic       s_in,
   output ctrl_t      ctl
);

   always_comb begin
      ctl = '0;
      if (valid) begin
         unique case (1'b1)
            (mode == MODE_DP): begin
               ctl.alu_cmd = alu_of(opcode);
               ctl.s_out   = s_in;
               ctl.wb_en   = !(opcode == OP_CMP || opcode == OP_TST);
            end
            (mode == MODE_MEM): begin
               ctl.alu_cmd   = ALU_ADD;
               ctl.mem_read  = s_in;
               ctl.wb_en     = s_in;
               ctl.mem_write = !s_in;
            end
            (mode == MODE_BR): begin
               ctl.alu_cmd = alu_of(opcode);
               ctl.branch  = 1'b1;
            end
            default: ctl.alu_cmd = alu_of(opcode);
         endcase
      end
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// Registered control decoder that expands SORT into compare/swap micro-ops,
// stalling the front end while the sequence runs.
module ctrl_sequencer
   import arm_ctrl_pkg::*;
#(
   parameter int SORT_PAIRS = 1,
   parameter int STEP_W     = (SORT_PAIRS < 1) ? 1 : $clog2(2 * SORT_PAIRS)
) (
   input  logic             clk,
   input  logic             rst,
   ctrl_sequencer_if.slave  bus
);

   localparam int T = 2 * SORT_PAIRS;
   localparam logic [STEP_W-1:0] LAST = STEP_W'(T - 1);

   state_t            state;
   ctrl_t             dec;
   ctrl_t             ctl;
   logic              valid_q;
   logic              last_q;
   logic              cap_s;
   logic [STEP_W-1:0] step_q;
   logic [STEP_W-1:0] nxt;
   logic              sort_hit;

   ctrl_decode u_dec (
      .valid  (bus.valid_in),
      .mode   (bus.mode),
      .opcode (bus.opcode),
      .s_in   (bus.s_in),
      .ctl    (dec)
   );

   assign sort_hit = bus.valid_in && bus.mode == MODE_DP
                     && bus.opcode == OP_SORT;
   assign nxt = step_q + STEP_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         ctl     <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         step_q  <= '0;
         cap_s   <= 1'b0;
      end else if (bus.flush) begin
         state   <= IDLE;
         ctl     <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         step_q  <= '0;
      end else if (!bus.freeze) begin
         unique case (state)
            IDLE: begin
               step_q <= '0;
               if (sort_hit) begin
                  state   <= SEQ;
                  cap_s   <= bus.s_in;
                  ctl     <= '{alu_cmd: ALU_SORT_CMP, default: '0};
                  valid_q <= 1'b1;
                  last_q  <= 1'b0;
               end else begin
                  ctl     <= dec;
                  valid_q <= bus.valid_in;
                  last_q  <= bus.valid_in;
               end
            end
            SEQ: begin
               // odd micro-ops are swaps and write back; S rides the last one
               ctl <= '{alu_cmd: nxt[0] ? ALU_SORT_SWP : ALU_SORT_CMP,
                        wb_en:   nxt[0],
                        s_out:   (nxt == LAST) && cap_s,
                        default: '0};
               valid_q <= 1'b1;
               last_q  <= (nxt == LAST);
               step_q  <= nxt;
               if (nxt == LAST) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.alu_cmd   = ctl.alu_cmd;
   assign bus.mem_read  = ctl.mem_read;
   assign bus.mem_write = ctl.mem_write;
   assign bus.wb_en     = ctl.wb_en;
   assign bus.branch    = ctl.branch;
   assign bus.s_out     = ctl.s_out;
   assign bus.valid_out = valid_q;
   assign bus.last_step = last_q;
   assign bus.step      = step_q;
   assign bus.stall_out = (state == SEQ);

endmodule
